scrambler: RTL and testbench



---
 rtl/scrambler_if.sv | 13 +
 rtl/scrambler.sv | 160 ++++++++++++++++
 tb/tb_scrambler.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scrambler_if.sv
// scrambler_if: valid/ready word stream carrying a start-of-frame marker.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface scrambler_if #(
  parameter int unsigned WS = 7
);
  logic          valid;
  logic          ready;
  logic [WS-1:0] word;
  logic          sof;

  modport master (output valid, output word, output sof, input ready);
  modport slave  (input valid, input word, input sof, output ready);
endinterface

// File: rtl/scrambler.sv
// scrambler: multiplicative (self-synchronizing) scrambler, WS bits per word, MSB first.
// Each scrambled bit is shifted back into the LFSR, so a matching descrambler recovers
// the data. The output side has a one-word register plus a one-word skid register,
// which keeps full throughput under backpressure.
// Optional build macro: SCRAMBLER_BYPASS_EN adds i_bypass. When i_bypass is high, the
// plaintext word is passed through unchanged, but the LFSR still advances exactly as it
// would for a scrambled word.
module scrambler #(
  parameter int unsigned     WS           = 7,
  parameter int unsigned     LN           = 31,
  parameter logic [LN-1:0]   TAPS         = 31'h00_00_20_01,
  parameter logic [LN-1:0]   INITIAL_FILL = {{(LN-1){1'b0}}, 1'b1}
) (
  input  logic               i_clk,
  input  logic               i_reset,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic               i_bypass,
`endif
  scrambler_if.slave         in_if,
  scrambler_if.master        out_if,
  output logic [15:0]        o_frames
);

  // Feedback parity over the tap-masked LFSR bits.
  function automatic logic parity_f(input logic [LN-1:0] v);
    parity_f = ^v;
  endfunction

  logic [LN-1:0] sreg_q, sreg_d;
  logic [15:0]   frames_q, frames_d;
  logic          out_valid_q, out_valid_d;
  logic [WS-1:0] out_word_q, out_word_d;
  logic          out_sof_q, out_sof_d;
  logic          skid_valid_q, skid_valid_d;
  logic [WS-1:0] skid_word_q, skid_word_d;
  logic          skid_sof_q, skid_sof_d;
  logic          ready_q, ready_d;

  logic [LN-1:0] lfsr_s;
  logic          fb_s;
  logic [WS-1:0] scr_word_s;
  logic [WS-1:0] new_word_s;
  logic          bypass_s;
  logic          accept_s;
  logic          drain_s;

`ifdef SCRAMBLER_BYPASS_EN
  assign bypass_s = i_bypass;
`else
  assign bypass_s = 1'b0;
`endif

  assign accept_s = in_if.valid && ready_q;
  assign drain_s  = out_valid_q && out_if.ready;

  // Scramble the presented word bit by bit, MSB first. Start from the fill on start-of-frame.
  always_comb begin
    fb_s       = 1'b0;
    scr_word_s = '0;
    if (in_if.sof) begin
      lfsr_s = INITIAL_FILL;
    end else begin
      lfsr_s = sreg_q;
    end
    for (int k = 0; k < int'(WS); k++) begin
      fb_s                  = in_if.word[WS-1-k] ^ parity_f(lfsr_s & TAPS);
      scr_word_s[WS-1-k]    = fb_s;
      lfsr_s                = {fb_s, lfsr_s[LN-1:1]};
    end
    if (bypass_s) begin
      new_word_s = in_if.word;
    end else begin
      new_word_s = scr_word_s;
    end
  end

  // Next state: the LFSR and frame count move on accept; the output/skid pair preserves order.
  always_comb begin
    sreg_d       = sreg_q;
    frames_d     = frames_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    out_sof_d    = out_sof_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    skid_sof_d   = skid_sof_q;

    if (accept_s) begin
      sreg_d = lfsr_s;
    end else begin
      sreg_d = sreg_q;
    end

    if (accept_s && in_if.sof) begin
      frames_d = frames_q + 16'd1;
    end else begin
      frames_d = frames_q;
    end

    if (skid_valid_q) begin
      // Input is stalled here; only a drain can make progress.
      if (drain_s) begin
        out_word_d   = skid_word_q;
        out_sof_d    = skid_sof_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (accept_s) begin
      if (!out_valid_q || drain_s) begin
        out_word_d  = new_word_s;
        out_sof_d   = in_if.sof;
        out_valid_d = 1'b1;
      end else begin
        skid_word_d  = new_word_s;
        skid_sof_d   = in_if.sof;
        skid_valid_d = 1'b1;
      end
    end else if (drain_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    ready_d = !skid_valid_d;
  end

  // State registers, cleared asynchronously by i_reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sreg_q       <= INITIAL_FILL;
      frames_q     <= 16'd0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      out_sof_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= '0;
      skid_sof_q   <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      sreg_q       <= sreg_d;
      frames_q     <= frames_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_sof_q    <= out_sof_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
      skid_sof_q   <= skid_sof_d;
      ready_q      <= ready_d;
    end
  end

  assign in_if.ready  = ready_q;
  assign out_if.valid = out_valid_q;
  assign out_if.word  = out_word_q;
  assign out_if.sof   = out_sof_q;
  assign o_frames     = frames_q;

endmodule

// File: tb/tb_scrambler.sv
// tb_scrambler: randomized self-checking bench for scrambler.
// The reference model keeps a history of transmitted bits and taps that history directly.
module tb_scrambler;

  localparam int          LN     = 31;
  localparam logic [30:0] TAPS_C = 31'h0000_2001;
  localparam logic [30:0] FILL_C = 31'h0000_0001;

  typedef struct packed {
    logic       ok;
    logic [6:0] word;
    logic       sof;
    logic [6:0] plain;
  } exp_t;

  logic        clk;
  logic        i_reset;
  logic        byp;
  logic [15:0] frames;
  int          checks;
  int          errors;

  exp_t exp_q[$];
  bit   hist[$];
  bit   dhist[$];

  scrambler_if #(.WS(7)) in_if ();
  scrambler_if #(.WS(7)) out_if ();

  scrambler dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
`ifdef SCRAMBLER_BYPASS_EN
    .i_bypass (byp),
`endif
    .in_if    (in_if),
    .out_if   (out_if),
    .o_frames (frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The transmit history starts as the fill: oldest is fill bit 0, newest is fill bit LN-1.
  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < LN; j++) hist.push_back(FILL_C[j]);
  endtask

  task automatic dmodel_reset();
    dhist.delete();
    for (int j = 0; j < LN; j++) dhist.push_back(FILL_C[j]);
  endtask

  // Tap j looks at the bit sent LN-j bit times ago.
  task automatic model_word(input logic [6:0] w, input logic sof, input logic bp,
                            output logic [6:0] res);
    logic [6:0] scr;
    logic       fb;
    if (sof) model_reset();
    for (int k = 6; k >= 0; k--) begin
      fb = 1'b0;
      for (int j = 0; j < LN; j++)
        if (TAPS_C[j]) fb = fb ^ hist[hist.size() - (LN - j)];
      scr[k] = w[k] ^ fb;
      hist.push_back(scr[k]);
      void'(hist.pop_front());
    end
    res = bp ? w : scr;
  endtask

  task automatic descramble(input logic [6:0] b, input logic sof, output logic [6:0] d);
    logic fb;
    if (sof) dmodel_reset();
    for (int k = 6; k >= 0; k--) begin
      fb = 1'b0;
      for (int j = 0; j < LN; j++)
        if (TAPS_C[j]) fb = fb ^ dhist[dhist.size() - (LN - j)];
      d[k] = b[k] ^ fb;
      dhist.push_back(b[k]);
      void'(dhist.pop_front());
    end
  endtask

  // Drive one cycle and report what the coming edge will accept and drain.
  task automatic cycle(input logic v, input logic [6:0] w, input logic s, input logic rdy,
                       input logic bp, output logic acc, output logic drn,
                       output logic [6:0] act_w, output logic act_s, output exp_t ex,
                       output logic vld, output logic rdyo, output int occ);
    logic [6:0] res;
    @(negedge clk);
    in_if.valid  = v;
    in_if.word   = w;
    in_if.sof    = s;
    out_if.ready = rdy;
    byp          = bp;
    vld   = out_if.valid;
    rdyo  = in_if.ready;
    occ   = exp_q.size();
    acc   = v && in_if.ready;
    drn   = out_if.valid && rdy;
    act_w = out_if.word;
    act_s = out_if.sof;
    ex    = '0;
    if (drn && exp_q.size() > 0) ex = exp_q.pop_front();
    if (acc) begin
      model_word(w, s, bp, res);
      exp_q.push_back({1'b1, res, s, w});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset      = 1'b1;
    in_if.valid  = 1'b0;
    in_if.word   = 7'h00;
    in_if.sof    = 1'b0;
    out_if.ready = 1'b1;
    byp          = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    model_reset();
    dmodel_reset();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_if.valid); end
    checks++; if (out_if.word !== 7'h00) begin errors++; $display("FAIL reset_word: got %h expected 00", out_if.word); end
    checks++; if (out_if.sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", out_if.sof); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_if.ready); end
    checks++; if (frames !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", frames); end
  endtask

  task automatic test_zero_words();
    logic [6:0] ref_w [3];
    logic acc, drn, as, vld, rdyo;
    logic [6:0] aw;
    exp_t ex;
    int occ;
    ref_w[0] = 7'h40; ref_w[1] = 7'h00; ref_w[2] = 7'h04;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(i < 3, 7'h00, 1'b0, 1'b1, 1'b0, acc, drn, aw, as, ex, vld, rdyo, occ);
      if (i == 0) begin
        checks++; if (drn !== 1'b0) begin errors++; $display("FAIL zero_early: got valid %b expected 0", drn); end
      end else begin
        checks++;
        if (drn !== 1'b1 || aw !== ref_w[i-1] || aw !== ex.word) begin
          errors++; $display("FAIL zero_word%0d: got valid %b word %h expected %h", i-1, drn, aw, ref_w[i-1]);
        end
      end
    end
  endtask

  task automatic test_loopback();
    logic acc, drn, as, vld, rdyo, s;
    logic [6:0] aw, d;
    exp_t ex;
    int occ, nsof;
    nsof = 0;
    do_reset();
    for (int i = 0; i <= 1000; i++) begin
      s = ($urandom_range(0, 99) < 5);
      cycle(i < 1000, 7'($urandom), s, 1'b1, 1'b0, acc, drn, aw, as, ex, vld, rdyo, occ);
      if (acc && s) nsof++;
      if (drn) begin
        descramble(aw, as, d);
        checks++;
        if (ex.ok !== 1'b1 || d !== ex.plain || as !== ex.sof || aw !== ex.word) begin
          errors++; $display("FAIL loopback%0d: got %h/%b descr %h expected %h/%b plain %h", i, aw, as, d, ex.word, ex.sof, ex.plain);
        end
      end
    end
    checks++; if (frames !== 16'(nsof)) begin errors++; $display("FAIL loopback_frames: got %0d expected %0d", frames, nsof); end
  endtask

  task automatic test_backpressure();
    logic [6:0] words [20];
    logic       sofs [20];
    logic [7:0] out_a[$];
    logic [7:0] out_b[$];
    logic acc, drn, as, vld, rdyo, rdy, prev_stall, prev_s;
    logic [6:0] aw, prev_w;
    exp_t ex;
    int occ, idx, c;
    for (int i = 0; i < 20; i++) begin
      words[i] = 7'($urandom);
      sofs[i]  = ($urandom_range(0, 9) == 0);
    end
    for (int run = 0; run < 2; run++) begin
      do_reset();
      idx = 0; c = 0; prev_stall = 1'b0; prev_w = 7'h00; prev_s = 1'b0;
      while ((idx < 20 || exp_q.size() > 0) && c < 400) begin
        rdy = (run == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        cycle(idx < 20, words[idx < 20 ? idx : 19], sofs[idx < 20 ? idx : 19], rdy, 1'b0,
              acc, drn, aw, as, ex, vld, rdyo, occ);
        if (run == 1) begin
          checks++; if (rdyo !== (occ < 2)) begin errors++; $display("FAIL bp_ready: got %b expected %b (occ %0d)", rdyo, occ < 2, occ); end
          checks++; if (vld !== (occ > 0)) begin errors++; $display("FAIL bp_valid: got %b expected %b", vld, occ > 0); end
          if (prev_stall) begin
            checks++;
            if (aw !== prev_w || as !== prev_s) begin errors++; $display("FAIL bp_stable: got %h/%b expected %h/%b", aw, as, prev_w, prev_s); end
          end
        end
        prev_stall = vld && !rdy; prev_w = aw; prev_s = as;
        if (acc) idx++;
        if (drn) begin
          checks++;
          if (ex.ok !== 1'b1 || aw !== ex.word || as !== ex.sof) begin
            errors++; $display("FAIL bp_model: got %h/%b expected %h/%b", aw, as, ex.word, ex.sof);
          end
          if (run == 0) out_a.push_back({as, aw}); else out_b.push_back({as, aw});
        end
        c++;
      end
      checks++; if (c >= 400) begin errors++; $display("FAIL bp_timeout: run %0d got %0d words expected 20", run, idx); end
    end
    checks++; if (out_b.size() !== 20 || out_a.size() !== 20) begin errors++; $display("FAIL bp_count: got %0d/%0d expected 20", out_a.size(), out_b.size()); end
    for (int i = 0; i < 20 && i < out_a.size() && i < out_b.size(); i++) begin
      checks++; if (out_b[i] !== out_a[i]) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", i, out_b[i], out_a[i]); end
    end
  endtask

  task automatic test_frame_restart();
    logic [6:0] ref_w [3];
    logic [6:0] got_w [6];
    logic       got_s [6];
    logic acc, drn, as, vld, rdyo;
    logic [6:0] aw;
    exp_t ex;
    int occ, n;
    ref_w[0] = 7'h40; ref_w[1] = 7'h00; ref_w[2] = 7'h04;
    n = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(i < 6, 7'h00, i == 3, 1'b1, 1'b0, acc, drn, aw, as, ex, vld, rdyo, occ);
      if (drn && n < 6) begin got_w[n] = aw; got_s[n] = as; n++; end
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL frame_count_out: got %0d expected 6", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_w[i+3] !== ref_w[i]) begin errors++; $display("FAIL frame_word%0d: got %h expected %h", i, got_w[i+3], ref_w[i]); end
    end
    checks++; if (got_s[3] !== 1'b1 || got_s[4] !== 1'b0 || got_s[2] !== 1'b0) begin
      errors++; $display("FAIL frame_sof: got %b%b%b expected 010", got_s[2], got_s[3], got_s[4]);
    end
    checks++; if (frames !== 16'd1) begin errors++; $display("FAIL frame_frames: got %0d expected 1", frames); end
  endtask

  task automatic test_async_reset();
    logic acc, drn, as, vld, rdyo;
    logic [6:0] aw;
    exp_t ex;
    int occ;
    do_reset();
    cycle(1'b1, 7'($urandom), 1'b0, 1'b0, 1'b0, acc, drn, aw, as, ex, vld, rdyo, occ);
    cycle(1'b1, 7'($urandom), 1'b0, 1'b0, 1'b0, acc, drn, aw, as, ex, vld, rdyo, occ);
    cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, acc, drn, aw, as, ex, vld, rdyo, occ);
    checks++; if (out_if.valid !== 1'b1 || in_if.ready !== 1'b0) begin
      errors++; $display("FAIL arst_pre: got valid %b ready %b expected 1 0", out_if.valid, in_if.ready);
    end
    #2;
    i_reset = 1'b1;
    #1;
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", out_if.valid); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", in_if.ready); end
    @(negedge clk);
    i_reset = 1'b0;
    model_reset();
    exp_q.delete();
    cycle(1'b1, 7'h00, 1'b0, 1'b1, 1'b0, acc, drn, aw, as, ex, vld, rdyo, occ);
    cycle(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, acc, drn, aw, as, ex, vld, rdyo, occ);
    checks++; if (drn !== 1'b1 || aw !== 7'h40) begin errors++; $display("FAIL arst_first: got valid %b word %h expected 40", drn, aw); end
  endtask

`ifdef SCRAMBLER_BYPASS_EN
  task automatic test_bypass();
    logic acc, drn, as, vld, rdyo;
    logic [6:0] aw, plain_second;
    logic [6:0] got [2];
    exp_t ex;
    int occ, n;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      n = 0;
      for (int i = 0; i < 3; i++) begin
        cycle(i < 2, (i == 0) ? 7'h55 : 7'h00, 1'b0, 1'b1, (run == 1 && i == 0),
              acc, drn, aw, as, ex, vld, rdyo, occ);
        if (drn && n < 2) begin
          got[n] = aw; n++;
          checks++; if (aw !== ex.word) begin errors++; $display("FAIL byp_model: got %h expected %h", aw, ex.word); end
        end
      end
      if (run == 0) plain_second = got[1];
    end
    checks++; if (got[0] !== 7'h55) begin errors++; $display("FAIL byp_pass: got %h expected 55", got[0]); end
    checks++; if (got[1] !== plain_second) begin errors++; $display("FAIL byp_seq: got %h expected %h", got[1], plain_second); end
  endtask
`endif

  initial begin
    checks       = 0;
    errors       = 0;
    i_reset      = 1'b1;
    byp          = 1'b0;
    in_if.valid  = 1'b0;
    in_if.word   = 7'h00;
    in_if.sof    = 1'b0;
    out_if.ready = 1'b1;
    test_reset();
    test_zero_words();
    test_loopback();
    test_backpressure();
    test_frame_restart();
    test_async_reset();
`ifdef SCRAMBLER_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
